tt_um_serial_adder: RTL and testbench
=====================================

TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ena, input, 1, design enable; state advances only while high.
REQ-004 SHALL have port ui_in, input, 8, operand data byte.
REQ-005 SHALL have port uio_in, input, 8, [0]=load_a, [1]=load_b, [2]=start, [3]=sub, [7:4] unused.
REQ-006 SHALL have port uo_out, output, 8, result register.
REQ-007 SHALL have port uio_out, output, 8, [3:0]=0, [4]=busy, [5]=done, [6]=carry, [7]=zero.
REQ-008 SHALL have port uio_oe, output, 8, constant 8'hF0.
REQ-009 SHALL provide power ports only under the gate-level flow, not in RTL.

Function
REQ-010 SHALL implement an 8-bit bit-serial adder: one full-adder bit per cycle, built from two half-adder cells plus a carry flip-flop, LSB first.
REQ-011 SHALL hold operand registers A and B; load_a=1 writes ui_in to A, load_b=1 writes ui_in to B, both may be written in the same cycle, and loads are accepted in any state.
REQ-012 SHALL use FSM states IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL copy A and B into shift registers, set carry to carry-in (0 for add), clear bit counter, clear done, set busy, and enter RUN.
REQ-014 When load and start coincide, the computation SHALL use the pre-edge operand values; the load still takes effect.
REQ-015 Each RUN edge SHALL compute sum/carry for the current bit, shift the sum bit into the result shift register, and increment the counter.
REQ-016 After the 8th RUN edge, the FSM SHALL enter DONE, update uo_out with the 8-bit sum, carry with the final carry, and zero with (sum==0), clear busy, and set done.
REQ-017 Latency SHALL be 9 edges: start sampled at edge N, result and done visible after edge N+8.
REQ-018 uo_out, carry, and zero SHALL hold the previous result throughout RUN and change only on entry to DONE.
REQ-019 start during RUN SHALL be ignored; done SHALL stay high in DONE until the next accepted start or reset.
REQ-020 With ena=0, all registers and the FSM SHALL hold their values; loads and start are ignored.
REQ-021 Sum width SHALL be 8 bits; overflow beyond bit 7 SHALL appear only on carry.

Reset
REQ-022 rst_n=0 SHALL immediately clear A, B, the shift registers, the counter, the result, and the carry, and force IDLE.
REQ-023 During reset, uo_out and uio_out SHALL be 0, and uio_oe SHALL be 8'hF0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no partial result visible; after release the block SHALL be in IDLE with done=0.

Configuration
REQ-025 With macro SERIAL_ADDER_SUB_EN defined, sub=1 at an accepted start SHALL compute A-B (B inverted bit-serially, carry-in 1), with carry=1 meaning no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN, uio_in[3] SHALL be ignored and every operation is A+B.

Verification
REQ-027 Load A=0x5A, B=0x3C, then start: after 8 edges, uo_out=0x96, carry=0, zero=0, done=1; busy is high for exactly 8 cycles.
REQ-028 Load A=0xFF, B=0x01, then start: result uo_out=0x00, carry=1, zero=1.
REQ-029 With SUB_EN, A=0x10, B=0x01, sub=1, start: uo_out=0x0F, carry=1. With A=0x01, B=0x02: uo_out=0xFF, carry=0.
REQ-030 Assert rst_n=0 at RUN cycle 4: uo_out=0, uio_out=0, IDLE. A subsequent load and start gives a correct result.
REQ-031 Pulse start during RUN and drop ena for 3 cycles mid-RUN: the result is unchanged, and done is delayed by exactly 3 cycles.
REQ-032 Apply load_a=1 with ui_in=0x22 and start in the same cycle, with old A=0x11 and B=0x01: result=0x12; a following start gives 0x23.

Source files
------------

// File: rtl/tt_um_serial_adder.sv
// Bit-serial 8-bit adder: one full-adder bit per clock, LSB first, 9-edge latency.
// Optional macro SERIAL_ADDER_SUB_EN adds A-B via uio_in[3] (carry=1 means no borrow).
module tt_um_serial_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [7:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
  logic [7:0] res_q, res_d;
  logic [2:0] cnt_q, cnt_d;
  logic       cy_q, cy_d, cout_q, cout_d, zero_q, zero_d;

  logic load_a, load_b, start, accept;
  logic sub_start, sub_run;
  logic bit_a, bit_b, ha1_s, ha1_c, ha2_s, ha2_c, sum_bit, carry_nxt;
  logic [7:0] sum_word;

  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];
  assign accept = start && (state_q != RUN);

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  assign sub_start = uio_in[3];
  assign sub_run   = sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               sub_q <= 1'b0;
    else if (ena && accept)   sub_q <= uio_in[3];
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:4]};
`else
  assign sub_start = 1'b0;
  assign sub_run   = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:3]};
`endif

  // Full adder built from two half-adder cells; subtraction inverts B on the fly.
  assign bit_a     = sa_q[0];
  assign bit_b     = sb_q[0] ^ sub_run;
  assign ha1_s     = bit_a ^ bit_b;
  assign ha1_c     = bit_a & bit_b;
  assign ha2_s     = ha1_s ^ cy_q;
  assign ha2_c     = ha1_s & cy_q;
  assign sum_bit   = ha2_s;
  assign carry_nxt = ha1_c | ha2_c;
  assign sum_word  = {sum_bit, sr_q[7:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    zero_d  = zero_q;

    if (load_a) a_d = ui_in;
    if (load_b) b_d = ui_in;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a_q;
          sb_d    = b_q;
          cy_d    = sub_start;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[7:1]};
        sb_d  = {1'b0, sb_q[7:1]};
        sr_d  = sum_word;
        cy_d  = carry_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          res_d   = sum_word;
          cout_d  = carry_nxt;
          zero_d  = (sum_word == 8'h00);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      sa_q    <= 8'h00;
      sb_q    <= 8'h00;
      sr_q    <= 8'h00;
      res_q   <= 8'h00;
      cnt_q   <= 3'd0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {zero_q, cout_q, (state_q == DONE), (state_q == RUN), 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Self-checking bench for tt_um_serial_adder: vector table, corner sequences, random ops vs arithmetic model.
module tb_tt_um_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int tests = 0;
  int fails = 0;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  tt_um_serial_adder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cy;
    logic       z;
  } vec_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain 8-bit arithmetic; subtraction reports carry=1 when no borrow.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] s;
    if (SUB_EN && sub) s = {(a >= b), 8'(a - b)};
    else               s = {1'b0, a} + {1'b0, b};
    return s;
  endfunction

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; uio_in = 8'h01; cyc();
    ui_in = b; uio_in = 8'h02; cyc();
    uio_in = 8'h00;
  endtask

  task automatic start_op(input logic sub);
    uio_in = sub ? 8'h0C : 8'h04;
    cyc();
    uio_in = 8'h00;
  endtask

  task automatic wait_done(input logic [7:0] prev, output int lat, output int bc, output logic hold);
    lat = 0; bc = 0; hold = 1'b1;
    while (!uio_out[5] && lat < 40) begin
      if (uio_out[4]) bc++;
      if (uo_out !== prev) hold = 1'b0;
      cyc();
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input logic [7:0] sum, input logic cy, input logic z);
    chk({nm, ".sum"},  uo_out, sum);
    chk({nm, ".cy"},   uio_out[6], cy);
    chk({nm, ".zero"}, uio_out[7], z);
    chk({nm, ".done"}, uio_out[5], 1'b1);
    chk({nm, ".busy"}, uio_out[4], 1'b0);
  endtask

  task automatic full_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [7:0] sum, input logic cy, input logic z);
    int lat, bc;
    logic hold;
    logic [7:0] prev;
    load_ab(a, b);
    prev = uo_out;
    start_op(sub);
    wait_done(prev, lat, bc, hold);
    chk({nm, ".lat"}, lat, 8);
    chk({nm, ".busycyc"}, bc, 8);
    chk({nm, ".hold"}, hold, 1'b1);
    check_result(nm, sum, cy, z);
  endtask

  initial begin
    vec_t tbl[$];
    int lat, bc;
    logic hold;
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic rs;

    tbl.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0});
    tbl.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0});
    tbl.push_back('{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b1});
`else
    tbl.push_back('{8'h10, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0});
    tbl.push_back('{8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0});
`endif

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    cyc(); cyc();
    chk("rst.uo_out", uo_out, 8'h00);
    chk("rst.uio_out", uio_out, 8'h00);
    chk("rst.uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    cyc();
    chk("idle.uio_out", uio_out, 8'h00);

    foreach (tbl[i])
      full_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sum, tbl[i].cy, tbl[i].z);

    // Start pulse during RUN plus 3 disabled cycles; loads while disabled are ignored.
    load_ab(8'h5A, 8'h3C);
    start_op(1'b0);
    uio_in = 8'h04; cyc();
    uio_in = 8'h00; cyc();
    ena = 1'b0; ui_in = 8'hEE; uio_in = 8'h07;
    cyc(); cyc(); cyc();
    uio_in = 8'h00; ena = 1'b1;
    wait_done(uo_out, lat, bc, hold);
    chk("ena.lat", lat + 5, 11);
    check_result("ena", 8'h96, 1'b0, 1'b0);
    start_op(1'b0);
    wait_done(uo_out, lat, bc, hold);
    check_result("ena.rerun", 8'h96, 1'b0, 1'b0);

    // Load and start in the same cycle: computation uses the old A.
    load_ab(8'h11, 8'h01);
    ui_in = 8'h22; uio_in = 8'h05; cyc();
    uio_in = 8'h00;
    wait_done(uo_out, lat, bc, hold);
    chk("ldst.lat", lat, 8);
    check_result("ldst", 8'h12, 1'b0, 1'b0);
    start_op(1'b0);
    wait_done(uo_out, lat, bc, hold);
    check_result("ldst2", 8'h23, 1'b0, 1'b0);

    // Reset at RUN cycle 4 aborts with nothing visible, and clears the operands.
    load_ab(8'hC8, 8'h64);
    start_op(1'b0);
    cyc(); cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst.uo_out", uo_out, 8'h00);
    chk("midrst.uio_out", uio_out, 8'h00);
    chk("midrst.uio_oe", uio_oe, 8'hF0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("midrst.idle", uio_out, 8'h00);
    start_op(1'b0);
    wait_done(uo_out, lat, bc, hold);
    check_result("postrst.zeroop", 8'h00, 1'b0, 1'b1);
    full_op("postrst", 8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      m  = model(ra, rb, rs);
      full_op($sformatf("rnd%0d_%02h_%02h_%0d", k, ra, rb, rs), ra, rb, rs, m[7:0], m[8], (m[7:0] == 8'h00));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
